// File: rtl/polar_pkg.sv
// Shared definitions for the polar-decoder processing element: mode
// encodings, the symmetric LLR limit and the saturating helpers used by
// the per-lane arithmetic.
package polar_pkg;

    localparam logic PE_F = 1'b0;
    localparam logic PE_G = 1'b1;

    // Largest magnitude an LLR may carry; the most-negative code is excluded.
    function automatic int llr_max(input int w);
        return (1 << (w - 1)) - 1;
    endfunction

    // Clip a value to the symmetric range [-llr_max(w), +llr_max(w)].
    function automatic int sat_sym(input int value, input int w);
        int lim;
        lim = llr_max(w);
        if (value > lim)
            return lim;
        else if (value < -lim)
            return -lim;
        else
            return value;
    endfunction

    // Magnitude of a w-bit code, mapping the most-negative code to llr_max(w).
    function automatic int abs_sat(input int value, input int w);
        int lim;
        lim = llr_max(w);
        if (value <= -(lim + 1))
            return lim;
        else if (value < 0)
            return -value;
        else
            return value;
    endfunction

endpackage

// File: rtl/polar_pe_lane.sv
// One lane of the polar PE, purely combinational. The first half prepares
// the operands captured by S1; the second half turns the S1 register
// contents into the f / g result and the lane saturation flag for S2.
module polar_pe_lane
    import polar_pkg::*;
#(
    parameter int W = 8
) (
    input  logic signed [W-1:0] x,
    input  logic signed [W-1:0] y,
    output logic signed [W:0]   s,
    output logic signed [W:0]   d,
    output logic [W-1:0]        ax,
    output logic [W-1:0]        ay,
    output logic                sgn,
    output logic                fx,
    output logic                fy,
    input  logic                mode_p1,
    input  logic                u_p1,
    input  logic signed [W:0]   s_p1,
    input  logic signed [W:0]   d_p1,
    input  logic [W-1:0]        ax_p1,
    input  logic [W-1:0]        ay_p1,
    input  logic                sgn_p1,
    input  logic                fx_p1,
    input  logic                fy_p1,
    output logic signed [W-1:0] res,
    output logic                sat
);

    localparam logic signed [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};

    logic [W-1:0]      m;
    logic              x_min;
    logic              y_min;
    logic signed [W:0] g_val;
    int                g_clip;

    // Operand preparation ahead of the S1 boundary; fx/fy remember which
    // magnitudes were forced so S2 can flag a saturated minimum.
    always_comb begin
        s   = $signed({x[W-1], x}) + $signed({y[W-1], y});
        d   = $signed({y[W-1], y}) - $signed({x[W-1], x});
        ax  = W'(abs_sat(int'(x), W));
        ay  = W'(abs_sat(int'(y), W));
        sgn = x[W-1] ^ y[W-1];
        fx  = (x == MOST_NEG);
        fy  = (y == MOST_NEG);
    end

    // Result selection ahead of the S2 boundary; a forced operand that ties
    // for the minimum counts as the selected one.
    always_comb begin
        x_min  = (ax_p1 <= ay_p1);
        y_min  = (ay_p1 <= ax_p1);
        m      = x_min ? ax_p1 : ay_p1;
        g_val  = u_p1 ? d_p1 : s_p1;
        g_clip = sat_sym(int'(g_val), W);
        if (mode_p1 == PE_G) begin
            res = W'(g_clip);
            sat = (g_clip != int'(g_val));
        end else begin
            res = sgn_p1 ? $signed(-m) : $signed(m);
            sat = (fx_p1 && x_min) || (fy_p1 && y_min);
        end
    end

endmodule

// File: rtl/polar_pe_pipe.sv
// Two-stage pipelined polar PE over LANES parallel LLR pairs with a
// bubble-collapsing valid/ready handshake and a saturating count of
// saturated lanes seen at the output.
module polar_pe_pipe
    import polar_pkg::*;
#(
    parameter int W     = 8,
    parameter int LANES = 4,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 mode,
    input  logic [LANES-1:0]     u,
    input  logic [LANES*W-1:0]   x,
    input  logic [LANES*W-1:0]   y,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [LANES*W-1:0]   llr_out,
    output logic                 sat_any,
    output logic [CNT_W-1:0]     sat_cnt,
    input  logic                 cnt_clr
);

    localparam int PW = $clog2(LANES + 1);
    localparam int SW = CNT_W + 1;

    logic vld_p1;
    logic vld_p2;
    logic ld_p1;
    logic ld_p2;
    logic fire;

    logic signed [W:0]   s_c  [LANES];
    logic signed [W:0]   d_c  [LANES];
    logic [W-1:0]        ax_c [LANES];
    logic [W-1:0]        ay_c [LANES];
    logic [LANES-1:0]    sgn_c;
    logic [LANES-1:0]    fx_c;
    logic [LANES-1:0]    fy_c;

    logic                mode_p1;
    logic [LANES-1:0]    u_p1;
    logic signed [W:0]   s_p1  [LANES];
    logic signed [W:0]   d_p1  [LANES];
    logic [W-1:0]        ax_p1 [LANES];
    logic [W-1:0]        ay_p1 [LANES];
    logic [LANES-1:0]    sgn_p1;
    logic [LANES-1:0]    fx_p1;
    logic [LANES-1:0]    fy_p1;

    logic [LANES*W-1:0]  llr_nxt;
    logic [LANES-1:0]    sat_nxt;
    logic [LANES-1:0]    sat_p2;

    logic [PW-1:0]       pop;
    logic [SW-1:0]       cnt_sum;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        polar_pe_lane #(.W(W)) u_lane (
            .x       (x[i*W +: W]),
            .y       (y[i*W +: W]),
            .s       (s_c[i]),
            .d       (d_c[i]),
            .ax      (ax_c[i]),
            .ay      (ay_c[i]),
            .sgn     (sgn_c[i]),
            .fx      (fx_c[i]),
            .fy      (fy_c[i]),
            .mode_p1 (mode_p1),
            .u_p1    (u_p1[i]),
            .s_p1    (s_p1[i]),
            .d_p1    (d_p1[i]),
            .ax_p1   (ax_p1[i]),
            .ay_p1   (ay_p1[i]),
            .sgn_p1  (sgn_p1[i]),
            .fx_p1   (fx_p1[i]),
            .fy_p1   (fy_p1[i]),
            .res     (llr_nxt[i*W +: W]),
            .sat     (sat_nxt[i])
        );
    end

    // Stage advance: S2 moves when empty or drained, S1 moves when empty or
    // when S2 takes its contents, so bubbles collapse.
    always_comb begin
        ld_p2     = !vld_p2 || out_ready;
        ld_p1     = !vld_p1 || ld_p2;
        in_ready  = ld_p1;
        out_valid = vld_p2;
        sat_any   = |sat_p2;
        fire      = vld_p2 && out_ready;
    end

    // S1 valid flag.
    always_ff @(posedge clk) begin
        if (rst)
            vld_p1 <= 1'b0;
        else if (ld_p1)
            vld_p1 <= in_valid;
    end

    // ---- S1 boundary: operands captured only on an accepted beat ----
    always_ff @(posedge clk) begin
        if (ld_p1 && in_valid) begin
            mode_p1 <= mode;
            u_p1    <= u;
            sgn_p1  <= sgn_c;
            fx_p1   <= fx_c;
            fy_p1   <= fy_c;
            for (int i = 0; i < LANES; i++) begin
                s_p1[i]  <= s_c[i];
                d_p1[i]  <= d_c[i];
                ax_p1[i] <= ax_c[i];
                ay_p1[i] <= ay_c[i];
            end
        end
    end

    // ---- S2 boundary: result and saturation flags, held under backpressure ----
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p2  <= 1'b0;
            llr_out <= '0;
            sat_p2  <= '0;
        end else if (ld_p2) begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                llr_out <= llr_nxt;
                sat_p2  <= sat_nxt;
            end
        end
    end

    // Number of saturated lanes in the beat at the output and the widened
    // running total used for overflow detection.
    always_comb begin
        pop = '0;
        for (int i = 0; i < LANES; i++)
            pop = pop + PW'(sat_p2[i]);
        cnt_sum = {1'b0, sat_cnt} + SW'(pop);
    end

    // Saturation event counter: clear wins, otherwise add on each handshake
    // and stick at all-ones.
    always_ff @(posedge clk) begin
        if (rst || cnt_clr)
            sat_cnt <= '0;
        else if (fire)
            sat_cnt <= cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
    end

endmodule
